// File: rtl/switch_cfg_ctrl_if.sv
// rtl/switch_cfg_ctrl_if.sv - config request and port-table memory bus bundle
// master is the config agent / memory side, slave is the sequencer.
interface switch_cfg_ctrl_if #(
  parameter int DATA_W = 8
);
  logic                  cfg_req;
  logic [4*DATA_W-1:0]   cfg_addrs;
  logic                  cfg_ack;
  logic                  cfg_done;
  logic                  cfg_err;
  logic                  busy;
  logic                  traffic_hold;
  logic                  mem_en;
  logic                  mem_rd_wr;
  logic [1:0]            mem_add;
  logic [DATA_W-1:0]     mem_data;

  modport master (
    output cfg_req, cfg_addrs,
    input  cfg_ack, cfg_done, cfg_err, busy, traffic_hold,
    input  mem_en, mem_rd_wr, mem_add, mem_data
  );

  modport slave (
    input  cfg_req, cfg_addrs,
    output cfg_ack, cfg_done, cfg_err, busy, traffic_hold,
    output mem_en, mem_rd_wr, mem_add, mem_data
  );
endinterface

// File: rtl/switch_cfg_ctrl.sv
// rtl/switch_cfg_ctrl.sv - port-address table configuration sequencer
// Latches four addresses, rejects duplicates, writes table slots 0..3 with gaps, then settles.
module switch_cfg_ctrl #(
  parameter int DATA_W        = 8,
  parameter int GAP_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int CHECK_DUP     = 1
) (
  input  logic              clk,
  input  logic              reset,
  switch_cfg_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, CHECK, WRITE, GAP, SETTLE} state_t;

  state_t              state, state_n;
  logic [1:0]          idx, idx_n, idx_nxt;
  logic [15:0]         cnt, cnt_n;
  logic [4*DATA_W-1:0] addrs_q, addrs_n;
  logic                dup;

  logic                ack_q, done_q, err_q, busy_q, hold_q, en_q;
  logic                ack_n, done_n, err_n, busy_n, hold_n, en_n;
  logic [1:0]          add_q, add_n;
  logic [DATA_W-1:0]   data_q, data_n;

  function automatic logic [DATA_W-1:0] slice(input logic [4*DATA_W-1:0] a, input logic [1:0] i);
    return a[i*DATA_W +: DATA_W];
  endfunction

  assign idx_nxt = idx + 2'd1;

  assign dup = (slice(addrs_q, 2'd0) == slice(addrs_q, 2'd1)) ||
               (slice(addrs_q, 2'd0) == slice(addrs_q, 2'd2)) ||
               (slice(addrs_q, 2'd0) == slice(addrs_q, 2'd3)) ||
               (slice(addrs_q, 2'd1) == slice(addrs_q, 2'd2)) ||
               (slice(addrs_q, 2'd1) == slice(addrs_q, 2'd3)) ||
               (slice(addrs_q, 2'd2) == slice(addrs_q, 2'd3));

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    addrs_n = addrs_q;
    ack_n   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    busy_n  = 1'b1;
    hold_n  = 1'b1;
    en_n    = 1'b0;
    add_n   = 2'd0;
    data_n  = '0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        hold_n = 1'b0;
        if (bus.cfg_req) begin
          addrs_n = bus.cfg_addrs;
          idx_n   = 2'd0;
          state_n = CHECK;
          ack_n   = 1'b1;
          busy_n  = 1'b1;
          hold_n  = 1'b1;
        end
      end
      CHECK: begin
        if (CHECK_DUP != 0 && dup) begin
          state_n = IDLE;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          hold_n  = 1'b0;
        end else begin
          state_n = WRITE;
          en_n    = 1'b1;
          add_n   = idx;
          data_n  = slice(addrs_q, idx);
        end
      end
      WRITE: begin
        if (idx != 2'd3) begin
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            cnt_n   = 16'd0;
          end else begin
            idx_n  = idx_nxt;
            en_n   = 1'b1;
            add_n  = idx_nxt;
            data_n = slice(addrs_q, idx_nxt);
          end
        end else if (SETTLE_CYCLES > 0) begin
          state_n = SETTLE;
          cnt_n   = 16'd0;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          hold_n  = 1'b0;
        end
      end
      GAP: begin
        if (cnt == 16'(GAP_CYCLES - 1)) begin
          state_n = WRITE;
          idx_n   = idx_nxt;
          en_n    = 1'b1;
          add_n   = idx_nxt;
          data_n  = slice(addrs_q, idx_nxt);
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      SETTLE: begin
        if (cnt == 16'(SETTLE_CYCLES - 1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          hold_n  = 1'b0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        hold_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 2'd0;
      cnt     <= 16'd0;
      addrs_q <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      en_q    <= 1'b0;
      add_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      addrs_q <= addrs_n;
      ack_q   <= ack_n;
      done_q  <= done_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      hold_q  <= hold_n;
      en_q    <= en_n;
      add_q   <= add_n;
      data_q  <= data_n;
    end
  end

  assign bus.cfg_ack      = ack_q;
  assign bus.cfg_done     = done_q;
  assign bus.cfg_err      = err_q;
  assign bus.busy         = busy_q;
  assign bus.traffic_hold = hold_q;
  assign bus.mem_en       = en_q;
  assign bus.mem_rd_wr    = en_q;
  assign bus.mem_add      = add_q;
  assign bus.mem_data     = data_q;
endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// tb/tb_switch_cfg_ctrl.sv - directed table-driven bench for switch_cfg_ctrl
// Three instances cover default, zero-gap/zero-settle and no-duplicate-check builds.
module tb_switch_cfg_ctrl;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  always #5 clk = ~clk;

  switch_cfg_ctrl_if #(.DATA_W(8)) b0();
  switch_cfg_ctrl_if #(.DATA_W(8)) b1();
  switch_cfg_ctrl_if #(.DATA_W(8)) b2();

  switch_cfg_ctrl #(.DATA_W(8)) dut0 (.clk(clk), .reset(rst0), .bus(b0.slave));
  switch_cfg_ctrl #(.DATA_W(8), .GAP_CYCLES(0), .SETTLE_CYCLES(0)) dut1 (.clk(clk), .reset(rst1), .bus(b1.slave));
  switch_cfg_ctrl #(.DATA_W(8), .CHECK_DUP(0)) dut2 (.clk(clk), .reset(rst2), .bus(b2.slave));

  typedef struct packed {
    logic       ack, done, err, busy, hold, en, rw;
    logic [1:0] add;
    logic [7:0] data;
  } obs_t;

  typedef struct {
    int          d;
    logic        req;
    logic [31:0] addrs;
    obs_t        exp;
    string       tag;
    int          cyc;
  } vec_t;

  vec_t vq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    case (d)
      0:       o = {b0.cfg_ack, b0.cfg_done, b0.cfg_err, b0.busy, b0.traffic_hold, b0.mem_en, b0.mem_rd_wr, b0.mem_add, b0.mem_data};
      1:       o = {b1.cfg_ack, b1.cfg_done, b1.cfg_err, b1.busy, b1.traffic_hold, b1.mem_en, b1.mem_rd_wr, b1.mem_add, b1.mem_data};
      default: o = {b2.cfg_ack, b2.cfg_done, b2.cfg_err, b2.busy, b2.traffic_hold, b2.mem_en, b2.mem_rd_wr, b2.mem_add, b2.mem_data};
    endcase
    return o;
  endfunction

  // A=ack, B=busy/hold only, W=write, D=done, E=err, anything else all-zero.
  function automatic obs_t mk(input byte c, input logic [7:0] data, input logic [1:0] add);
    obs_t o = '0;
    case (c)
      "A": begin o.ack = 1'b1; o.busy = 1'b1; o.hold = 1'b1; end
      "B": begin o.busy = 1'b1; o.hold = 1'b1; end
      "W": begin o.busy = 1'b1; o.hold = 1'b1; o.en = 1'b1; o.rw = 1'b1; o.add = add; o.data = data; end
      "D": o.done = 1'b1;
      "E": o.err = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input int cyc, input obs_t got, input obs_t exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got {ack,done,err,busy,hold,en,rw,add,data}=%b_%h expected %b_%h",
               tag, cyc, got[16:8], got.data, exp[16:8], exp.data);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic [31:0] a);
    b0.cfg_req = 1'b0; b1.cfg_req = 1'b0; b2.cfg_req = 1'b0;
    case (d)
      0:       begin b0.cfg_req = r; b0.cfg_addrs = a; end
      1:       begin b1.cfg_req = r; b1.cfg_addrs = a; end
      default: begin b2.cfg_req = r; b2.cfg_addrs = a; end
    endcase
  endtask

  // reqs: '1' req with a0, '2' req with a1, 'j' req with junk, '0' no req with junk.
  task automatic push_seq(input int d, input string tag, input string code, input string reqs,
                          input logic [31:0] a0, input logic [31:0] a1);
    int w = 0;
    for (int i = 0; i < code.len(); i++) begin
      vec_t        v;
      byte         c = code[i];
      byte         r = reqs[i];
      logic [31:0] lat;
      logic [7:0]  data = 8'h00;
      logic [1:0]  add  = 2'd0;
      v.d     = d;
      v.tag   = tag;
      v.cyc   = i;
      v.req   = (r != "0");
      v.addrs = (r == "1") ? a0 : (r == "2") ? a1 : ~a0;
      if (c == "W") begin
        lat  = (w < 4) ? a0 : a1;
        data = lat[(w % 4) * 8 +: 8];
        add  = 2'(w % 4);
        w++;
      end
      v.exp = mk(c, data, add);
      vq.push_back(v);
    end
  endtask

  task automatic run_vecs();
    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      drive(vq[i].d, vq[i].req, vq[i].addrs);
      @(negedge clk);
      check(vq[i].tag, vq[i].cyc, get_obs(vq[i].d), vq[i].exp);
    end
    vq.delete();
    drive(0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    b0.cfg_req = 1'b0; b1.cfg_req = 1'b0; b2.cfg_req = 1'b0;
    b0.cfg_addrs = '0; b1.cfg_addrs = '0; b2.cfg_addrs = '0;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check("reset_state", d, get_obs(d), '0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    push_seq(0, "default", "0AWBWBWBWBBD0", "1000000000000", 32'h44332211, 32'h0);
    push_seq(0, "dup_reject", "0AE00", "10000", 32'h10201030, 32'h0);
    push_seq(0, "held_req", "0AWBWBWBWBBDAWBWBWBWBBD0", "1jjjjjjjjjj2000000000000",
             32'h8C7B6A59, 32'hA4A3A2A1);
    push_seq(1, "gap0_settle0", "0AWWWWD00", "100000000", 32'h44332211, 32'h0);
    push_seq(2, "nodup_check", "0AWBWBWBWBBD0", "1000000000000", 32'h55555555, 32'h0);
    run_vecs();

    // Reset during the second write must drop mem_en immediately and suppress completion.
    @(posedge clk); #1 drive(0, 1'b1, 32'hA1B2C3D4);
    @(posedge clk); #1 drive(0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_write", 4, get_obs(0), mk("W", 8'hC3, 2'd1));
    rst0 = 1'b1;
    #1;
    check("async_reset", 4, get_obs(0), '0);
    @(posedge clk); #1 rst0 = 1'b0;
    dn = 0;
    repeat (14) begin
      @(negedge clk);
      if (b0.cfg_done || b0.cfg_err || b0.busy || b0.mem_en) dn++;
    end
    n_run++;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d active cycles after reset, expected 0", dn);
    end
    push_seq(0, "post_reset", "0AWBWBWBWBBD0", "1000000000000", 32'h0F0E0D0C, 32'h0);
    run_vecs();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
